uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one rs232tx serial transmitter between N byte-stream requesters, such as the rx echo path and a status/message generator.
- Arbitration is round-robin at packet granularity. Once a requester sends a non-last byte, it holds the transmitter until it sends a byte marked last or an idle timeout expires.
- Sits between the requesters and rs232tx in bemicrocv. It drives the rs232tx d/we inputs and observes its busy output.

Parameters:
- N, 2, number of requesters (1..8).
- TIMEOUT, 50_000_000, cycles a locked owner may leave req_valid low before its lock is revoked. 0 disables the timeout.

Ports:
- clock  input  1  system clock (clk_50).
- reset  input  1  synchronous, active-high reset.
- req_valid  input  N  requester i has a byte pending.
- req_last  input  N  requester i's byte ends its packet.
- req_data  input  8*N  byte i occupies bits [8i+7:8i].
- req_ready  output  N  byte i is accepted this cycle when req_valid[i] & req_ready[i].
- tx_d  output  8  byte to rs232tx d; registered.
- tx_we  output  1  one-cycle write strobe to rs232tx we; registered.
- tx_busy  input  1  rs232tx busy.
- owner  output  log2(N) (min 1)  current or last granted requester.
- locked  output  1  a packet is in progress for owner.
- timeout  output  1  one-cycle pulse when a lock is revoked.

Behaviour:
- Reset values: req_ready=0, tx_we=0, tx_d=0, owner=0, locked=0, timeout=0, rr pointer=0, timeout counter=0, state=IDLE.
- State IDLE:
  - Grant candidate: owner if locked. Otherwise, the first i with req_valid[i] scanning from the rr pointer upward, modulo N.
  - req_ready[g] = (state==IDLE) & !tx_busy & candidate exists. All other req_ready bits are 0.
  - req_ready is combinational from state, tx_busy, req_valid and lock state, but must not depend on the same-cycle tx_we.
- Accept (valid & ready on requester g):
  - Next cycle: tx_d = byte g, tx_we = 1, owner = g, state = SEND.
  - If req_last[g]=0: locked <= 1.
  - If req_last[g]=1: locked <= 0 and the rr pointer <= (g+1) mod N.
- SEND: tx_we=1 for exactly this cycle. Next state is GAP.
- GAP: one cycle. tx_busy is ignored here to cover rs232tx's registered busy rise. Next state is DRAIN.
- DRAIN: stay while tx_busy=1. Go to IDLE on the first cycle tx_busy=0.
- Throughput: byte-to-byte minimum is 3 cycles plus the rs232tx busy time. At most one byte is in flight.
- Timeout:
  - Counts only while state==IDLE, locked=1, req_valid[owner]=0. Clears on any accept or when locked=0.
  - When the count reaches TIMEOUT-1: locked <= 0, rr pointer <= (owner+1) mod N, timeout pulses 1 cycle.
  - In that expiry cycle req_ready stays with the owner, so a simultaneous req_valid[owner] is accepted and the timeout does not fire.
- Boundaries:
  - Non-owner requesters are never granted while locked, regardless of their valid.
  - N=1: the rr pointer stays 0.
  - A requester may raise or drop req_valid at any time. Only the cycle with valid & ready transfers.
  - req_data and req_last are sampled only on accept.
- Reset mid-operation: all registers return to reset values and any in-progress tx_we is dropped. rs232tx has no reset, so a byte already on the wire completes. The controller grants nothing until tx_busy=0, because req_ready requires !tx_busy.

Test Plan:
- Single byte, N=2, rs232tx model with busy=1 for 10 cycles after we:
  - Stimulus: req_valid=01, req_last=01, data0=0x41.
  - Required: one tx_we pulse with tx_d=0x41, one cycle after accept; req_ready=0 until DRAIN exits; rr pointer=1.
- Round-robin fairness:
  - Stimulus: both requesters continuously valid with last=1, data0=0xA0, data1=0xB1.
  - Required: tx_d sequence 0xA0, 0xB1, 0xA0, 0xB1; owner alternates.
- Packet lock:
  - Stimulus: requester 0 sends 0x10,0x11,0x12 with last on 0x12; requester 1 valid throughout.
  - Required: tx_d is 0x10,0x11,0x12, then requester 1's byte; req_ready[1]=0 while locked=1.
- Timeout, TIMEOUT=20:
  - Stimulus: requester 0 sends a non-last byte, then drops valid; requester 1 valid.
  - Required: timeout pulse 20 idle cycles after returning to IDLE; locked=0; requester 1 granted next cycle.
- Timeout race:
  - Stimulus: owner re-raises valid in the expiry cycle.
  - Required: its byte is accepted, no timeout pulse, locked remains per req_last.
- Reset mid-DRAIN:
  - Stimulus: assert reset with tx_busy=1 and held high 5 more cycles.
  - Required: tx_we=0, req_ready=0 until tx_busy falls; owner=0, locked=0; first grant goes to requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte-stream bundle for uart_tx_arbiter.
// Byte i of req_data sits in req_data[i] (bits [8i+7:8i]).
interface uart_tx_arbiter_if #(
  parameter int N = 2
) ();
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_last;
  logic [N-1:0][7:0] req_data;
  logic [N-1:0]      req_ready;

  modport master (output req_valid, output req_last, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_last, input  req_data, output req_ready);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one rs232tx between N requesters.
// One byte in flight at a time: IDLE -> SEND -> GAP -> DRAIN -> IDLE.
module uart_tx_arb_lane #(
  parameter int            OW  = 1,
  parameter logic [OW-1:0] IDX = '0
) (
  input  logic          grant_en,
  input  logic [OW-1:0] cand,
  input  logic          valid,
  input  logic          last,
  input  logic [7:0]    data,
  output logic          ready,
  output logic          acc,
  output logic          take_last,
  output logic [7:0]    take_data
);
  assign ready     = grant_en && (cand == IDX);
  assign acc       = ready && valid;
  assign take_last = acc && last;
  assign take_data = acc ? data : 8'h00;
endmodule

module uart_tx_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 50_000_000,
  localparam int OW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_50,
  input  logic          rst,
  uart_tx_arbiter_if.slave req,
  output logic [7:0]    tx_d,
  output logic          tx_we,
  input  logic          tx_busy,
  output logic [OW-1:0] owner,
  output logic          locked,
  output logic          timeout
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DRAIN} state_t;

  state_t            state;
  logic [OW-1:0]     rr_ptr;
  logic [CW-1:0]     to_cnt;
  logic [OW-1:0]     cand;
  logic              cand_ok;
  logic              grant_en;
  logic [N-1:0]      ready_v;
  logic [N-1:0]      acc_v;
  logic [N-1:0]      last_v;
  logic [N-1:0][7:0] data_v;
  logic [7:0]        acc_data;
  logic              acc_last;
  logic              accept;
  logic              to_run;

  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] g);
    return (int'(g) == N - 1) ? '0 : g + 1'b1;
  endfunction

  // A locked owner keeps the grant even with valid low, so the timeout race
  // resolves in the owner's favour.
  always_comb begin
    int best_d;
    int d;
    best_d  = N;
    d       = 0;
    cand    = owner;
    cand_ok = locked;
    if (!locked) begin
      for (int i = 0; i < N; i++) begin
        d = (i + N - int'(rr_ptr)) % N;
        if (req.req_valid[i] && d < best_d) begin
          best_d  = d;
          cand    = OW'(i);
          cand_ok = 1'b1;
        end
      end
    end
  end

  assign grant_en = (state == IDLE) && !tx_busy && cand_ok && !rst;

  for (genvar i = 0; i < N; i++) begin : g_lane
    uart_tx_arb_lane #(.OW(OW), .IDX(OW'(i))) u_lane (
      .grant_en  (grant_en),
      .cand      (cand),
      .valid     (req.req_valid[i]),
      .last      (req.req_last[i]),
      .data      (req.req_data[i]),
      .ready     (ready_v[i]),
      .acc       (acc_v[i]),
      .take_last (last_v[i]),
      .take_data (data_v[i])
    );
  end

  assign req.req_ready = ready_v;
  assign accept        = |acc_v;
  assign to_run        = (state == IDLE) && locked && !req.req_valid[owner];

  always_comb begin
    acc_data = 8'h00;
    acc_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      acc_data = acc_data | data_v[i];
      acc_last = acc_last | last_v[i];
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state   <= IDLE;
      tx_d    <= 8'h00;
      tx_we   <= 1'b0;
      owner   <= '0;
      locked  <= 1'b0;
      timeout <= 1'b0;
      rr_ptr  <= '0;
      to_cnt  <= '0;
    end else begin
      tx_we   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          tx_d   <= acc_data;
          tx_we  <= 1'b1;
          owner  <= cand;
          state  <= SEND;
          locked <= !acc_last;
          if (acc_last) rr_ptr <= next_idx(cand);
        end
        SEND:    state <= GAP;
        // rs232tx raises busy a cycle late, so GAP never looks at it.
        GAP:     state <= DRAIN;
        DRAIN:   if (!tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (accept || !locked) begin
        to_cnt <= '0;
      end else if (to_run && TIMEOUT != 0) begin
        if (to_cnt == TO_LAST) begin
          locked  <= 1'b0;
          rr_ptr  <= next_idx(owner);
          timeout <= 1'b1;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N=2, TIMEOUT=20) with a simple rs232tx busy model.
module tb_uart_tx_arbiter;
  logic       clk_50 = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_d;
  logic       tx_we;
  logic       tx_busy;
  logic       owner;
  logic       locked;
  logic       timeout;
  logic       force_busy = 1'b0;
  int         busy_cnt = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         viol = 1'b0;

  uart_tx_arbiter_if #(.N(2)) rif ();

  uart_tx_arbiter #(.N(2), .TIMEOUT(20)) dut (
    .clk_50 (clk_50),
    .rst    (rst),
    .req    (rif),
    .tx_d   (tx_d),
    .tx_we  (tx_we),
    .tx_busy(tx_busy),
    .owner  (owner),
    .locked (locked),
    .timeout(timeout)
  );

  always #5 clk_50 = ~clk_50;

  // rs232tx stand-in: busy rises the cycle after we and lasts 10 cycles.
  always @(posedge clk_50) begin
    if (tx_we) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || force_busy;

  typedef struct {
    logic [1:0] v;
    logic [1:0] l;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] exp_d;
    logic       exp_own;
    logic       exp_lk;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_50);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic [7:0] d0, input logic [7:0] d1);
    rif.req_valid   = v;
    rif.req_last    = l;
    rif.req_data[0] = d0;
    rif.req_data[1] = d1;
  endtask

  task automatic wait_we(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (locked && rif.req_ready[1]) viol = 1'b1;
      if (tx_we) seen = 1'b1;
    end
    chk(nm, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_idle_owner0(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (rif.req_ready == 2'b01) seen = 1'b1;
      else tick();
    end
    chk(nm, {31'd0, seen}, 32'd1);
  endtask

  task automatic do_reset();
    bit quiet;
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    quiet = 1'b0;
    for (int i = 0; i < 100 && !quiet; i++) begin
      tick();
      if (!tx_busy) quiet = 1'b1;
    end
    chk("reset_busy_low", {31'd0, quiet}, 32'd1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int  k;
    bit  bad;
    logic [1:0] rdy0;
    int  we_cnt;

    tbl[0] = '{2'b11, 2'b11, 8'hA0, 8'hB1, 8'hA0, 1'b0, 1'b0};
    tbl[1] = '{2'b11, 2'b11, 8'hA0, 8'hB1, 8'hB1, 1'b1, 1'b0};
    tbl[2] = '{2'b11, 2'b11, 8'hA0, 8'hB1, 8'hA0, 1'b0, 1'b0};
    tbl[3] = '{2'b11, 2'b11, 8'hA0, 8'hB1, 8'hB1, 1'b1, 1'b0};
    tbl[4] = '{2'b11, 2'b00, 8'h10, 8'hC1, 8'h10, 1'b0, 1'b1};
    tbl[5] = '{2'b11, 2'b00, 8'h11, 8'hC1, 8'h11, 1'b0, 1'b1};
    tbl[6] = '{2'b11, 2'b01, 8'h12, 8'hC1, 8'h12, 1'b0, 1'b0};
    tbl[7] = '{2'b11, 2'b11, 8'h13, 8'hC1, 8'hC1, 1'b1, 1'b0};
    tbl[8] = '{2'b11, 2'b11, 8'h13, 8'hC1, 8'h13, 1'b0, 1'b0};

    drive(2'b00, 2'b00, 8'h00, 8'h00);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_tx_we",   {31'd0, tx_we}, 32'd0);
    chk("rst_tx_d",    {24'd0, tx_d}, 32'd0);
    chk("rst_owner",   {31'd0, owner}, 32'd0);
    chk("rst_locked",  {31'd0, locked}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_ready",   {30'd0, rif.req_ready}, 32'd0);

    // Single byte: one we pulse, ready low through SEND/GAP/DRAIN.
    drive(2'b01, 2'b01, 8'h41, 8'h00);
    #1;
    chk("single_ready", {30'd0, rif.req_ready}, 32'h1);
    tick();
    chk("single_we",    {31'd0, tx_we}, 32'd1);
    chk("single_d",     {24'd0, tx_d}, 32'h41);
    chk("single_owner", {31'd0, owner}, 32'd0);
    k = 0;
    we_cnt = 0;
    rdy0 = rif.req_ready;
    while (rdy0 == 2'b00 && k < 60) begin
      if (tx_we) we_cnt++;
      k++;
      tick();
      rdy0 = rif.req_ready;
    end
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    chk("single_busy_cycles", k, 32'd12);
    chk("single_we_pulses", we_cnt, 32'd1);
    chk("single_ready_back", {30'd0, rdy0}, 32'h1);
    drive(2'b11, 2'b11, 8'h00, 8'h00);
    #1;
    chk("single_rr_next", {30'd0, rif.req_ready}, 32'h2);
    drive(2'b00, 2'b00, 8'h00, 8'h00);

    // Round-robin and packet lock vectors.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      viol = 1'b0;
      drive(tbl[i].v, tbl[i].l, tbl[i].d0, tbl[i].d1);
      wait_we($sformatf("vec%0d_we", i));
      chk($sformatf("vec%0d_d", i),      {24'd0, tx_d}, {24'd0, tbl[i].exp_d});
      chk($sformatf("vec%0d_owner", i),  {31'd0, owner}, {31'd0, tbl[i].exp_own});
      chk($sformatf("vec%0d_locked", i), {31'd0, locked}, {31'd0, tbl[i].exp_lk});
      chk($sformatf("vec%0d_nonowner_ready", i), {31'd0, viol}, 32'd0);
    end

    // Timeout: owner goes quiet while locked.
    do_reset();
    drive(2'b01, 2'b00, 8'h55, 8'h66);
    wait_we("to_first_we");
    drive(2'b10, 2'b10, 8'h55, 8'h66);
    wait_idle_owner0("to_idle");
    k = 0;
    while (!timeout && k < 60) begin
      tick();
      k++;
    end
    chk("to_cycles", k, 32'd20);
    chk("to_locked", {31'd0, locked}, 32'd0);
    chk("to_ready1", {30'd0, rif.req_ready}, 32'h2);
    tick();
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    chk("to_pulse_width", {31'd0, timeout}, 32'd0);
    chk("to_grant_we",    {31'd0, tx_we}, 32'd1);
    chk("to_grant_d",     {24'd0, tx_d}, 32'h66);
    chk("to_grant_owner", {31'd0, owner}, 32'd1);

    // Timeout race: owner returns in the expiry cycle.
    do_reset();
    drive(2'b01, 2'b00, 8'h77, 8'h00);
    wait_we("race_first_we");
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    wait_idle_owner0("race_idle");
    bad = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (timeout) bad = 1'b1;
    end
    drive(2'b01, 2'b01, 8'h78, 8'h00);
    tick();
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    chk("race_we", {31'd0, tx_we}, 32'd1);
    chk("race_d",  {24'd0, tx_d}, 32'h78);
    chk("race_locked", {31'd0, locked}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (timeout) bad = 1'b1;
      tick();
    end
    chk("race_no_timeout", {31'd0, bad}, 32'd0);

    // Reset while draining with rs232tx still busy.
    do_reset();
    drive(2'b10, 2'b00, 8'h00, 8'h99);
    wait_we("rstd_we");
    chk("rstd_d", {24'd0, tx_d}, 32'h99);
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    tick();
    tick();
    chk("rstd_pre_locked", {31'd0, locked}, 32'd1);
    force_busy = 1'b1;
    rst = 1'b1;
    drive(2'b11, 2'b11, 8'hAA, 8'hBB);
    tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (tx_we || rif.req_ready != 2'b00 || owner || locked) bad = 1'b1;
      tick();
    end
    force_busy = 1'b0;
    k = 0;
    while (tx_busy && k < 60) begin
      if (tx_we || rif.req_ready != 2'b00) bad = 1'b1;
      tick();
      k++;
    end
    chk("rstd_busy_released", {31'd0, tx_busy}, 32'd0);
    chk("rstd_quiet", {31'd0, bad}, 32'd0);
    chk("rstd_first_ready", {30'd0, rif.req_ready}, 32'h1);
    tick();
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    chk("rstd_first_we",    {31'd0, tx_we}, 32'd1);
    chk("rstd_first_d",     {24'd0, tx_d}, 32'hAA);
    chk("rstd_first_owner", {31'd0, owner}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
